rom_bus_responder: RTL and testbench
====================================

Name: rom_bus_responder

Overview:
- ROM-side (4001-style) end of the 8-phase instruction bus driven by the CPU cycle generator.
- Tracks the cycle phase from the SYNC pulse alone, captures the 12-bit address nibbles in A1–A3, and checks chip select against CHIP_ID.
- When selected, fetches a byte from an attached ROM array and drives OPR in M1 and OPA in M2.
- Sits between the CPU data bus and the program ROM storage.

Parameters:
- CHIP_ID, 4'd0, value of address high nibble (A3) that selects this chip.
- ROM_AW, 8, ROM array address width; fixed at 8 (256 bytes per chip).

Ports:
- toggle_clk  input  1  system clock, same edge as the cycle generator.
- rst_n  input  1  reset.
- sync  input  1  high for exactly one clock during X3 (phase 7).
- d_in  input  4  data bus as driven by CPU.
- d_out  output  4  nibble this block drives onto the bus.
- d_oe  output  1  bus drive enable for d_out.
- rom_addr  output  8  byte address to ROM array.
- rom_data  input  8  ROM byte; combinational from rom_addr, valid within one clock.
- phase  output  3  tracked phase (0=A1 … 7=X3).
- locked  output  1  phase tracking valid.
- selected  output  1  current cycle addresses this chip.
- sync_err  output  1  one-clock pulse on SYNC protocol violation.

Behaviour:
- One clock (toggle_clk); reset is asynchronous and active-low (rst_n).
- Reset values: phase=0, locked=0, selected=0, d_oe=0, d_out=0, rom_addr=0, sync_err=0, internal addr=0.
- Phase tracker (two states, UNLOCKED and LOCKED), evaluated at each posedge:
  - sync=1 in either state → phase<=0, locked<=1.
  - LOCKED, sync=0, phase!=7 → phase<=phase+1.
  - LOCKED, sync=1, phase!=7 → sync_err<=1; resync (phase<=0, stay locked).
  - LOCKED, phase==7, sync=0 → sync_err<=1, locked<=0, phase<=0.
  - UNLOCKED, sync=0 → hold phase=0; no bus activity.
- Address capture, only while locked and sync=0:
  - posedge with phase==0 → addr[3:0]<=d_in.
  - posedge with phase==1 → addr[7:4]<=d_in; rom_addr<={d_in, addr[3:0]}. rom_addr is therefore valid throughout phase 2.
  - posedge with phase==2 → selected<=(d_in==CHIP_ID). If selected: d_out<=rom_data[7:4], d_oe<=1.
  - posedge with phase==3 → if selected: d_out<=rom_data[3:0] (rom_addr unchanged, so data is stable).
  - posedge with phase==4 → d_oe<=0, d_out<=0.
  - posedge with phase==7 (sync) → selected<=0.
- Resulting bus timing: d_oe is high for exactly two clocks (phases 3 and 4), carrying OPR then OPA. It is never high outside phases 3–4.
- Any sync_err or loss of lock forces d_oe<=0 and selected<=0 on the same edge.
- rst_n assertion mid-drive: d_oe drops asynchronously.
- After rst_n release: no drive until the first sync, then a full A1–A3 capture.
- rom_addr holds its value between cycles; no pipelining across cycles.

Decomposition:
- Shared package holds phase constants A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
  - The cycle generator uses the same package.
- Natural sub-module: cycle_tracker (sync → phase, locked, sync_err).
  - Reusable by the RAM-side responder.

Test Plan:
- Reset then 3 SYNC periods with no d_in activity → locked=1 after the first sync edge; phase counts 0..7 repeatedly; d_oe stays 0 because d_in(A3)=0xF ≠ CHIP_ID.
- CHIP_ID=0, d_in A1=0x4, A2=0xA, A3=0x0, rom[0xA4]=0x5C → rom_addr=0xA4 in phase 2; d_out=0x5 with d_oe=1 in M1; d_out=0xC in M2; d_oe=0 from X1.
- Same sequence with A3=0x3 → selected=0; d_oe stays 0; rom_addr still 0xA4.
- Inject an extra sync at phase 4 → sync_err pulse for one clock; phase returns to 0 next edge; d_oe=0; the next cycle fetches correctly.
- Suppress sync at phase 7 → sync_err=1, locked=0, phase held 0; relock on the next sync.
- Assert rst_n low during M1 with d_oe=1 → d_oe=0 immediately; all outputs at reset values; no drive until after the next sync plus A3.

Source files
------------

// File: rtl/rom_bus_responder_pkg.sv
// Shared definitions for the 8-phase instruction bus (cycle generator and responders).
package rom_bus_responder_pkg;

  // Bus cycle phases, one clock each; SYNC is high during X3.
  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } phase_e;

  typedef enum logic {
    TRK_UNLOCKED = 1'b0,
    TRK_LOCKED   = 1'b1
  } trk_state_e;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/rom_bus_responder_if.sv
// 4-bit instruction data bus plus SYNC, CPU (master) to ROM responder (slave).
interface rom_bus_responder_if;
  logic       sync;
  logic [3:0] d_in;
  logic [3:0] d_out;
  logic       d_oe;

  modport master (output sync, d_in, input  d_out, d_oe);
  modport slave  (input  sync, d_in, output d_out, d_oe);
endinterface

// File: rtl/rom_bus_responder_cycle_tracker.sv
// Recovers the bus phase from SYNC alone and flags SYNC protocol violations.
module cycle_tracker
  import rom_bus_responder_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_sync,
  output phase_e o_phase,
  output logic   o_locked,
  output logic   o_sync_err,
  output logic   o_fault     // violation detected on the coming edge
);

  trk_state_e r_state, w_nstate;
  phase_e     r_phase, w_nphase;
  logic       r_err,   w_nerr;

  // State, phase and error pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TRK_UNLOCKED;
      r_phase <= A1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_phase <= w_nphase;
      r_err   <= w_nerr;
    end
  end

  // Next state: SYNC always realigns; a SYNC early or missing is an error
  always_comb begin
    w_nstate = r_state;
    w_nphase = r_phase;
    w_nerr   = 1'b0;
    case (r_state)
      TRK_UNLOCKED: begin
        w_nphase = A1;
        if (i_sync) w_nstate = TRK_LOCKED;
      end
      TRK_LOCKED: begin
        if (i_sync) begin
          w_nphase = A1;
          w_nerr   = (r_phase != X3);
        end else if (r_phase == X3) begin
          w_nerr   = 1'b1;
          w_nstate = TRK_UNLOCKED;
          w_nphase = A1;
        end else begin
          w_nphase = phase_e'(r_phase + 3'd1);
        end
      end
      default: w_nstate = TRK_UNLOCKED;
    endcase
  end

  assign o_phase    = r_phase;
  assign o_locked   = (r_state == TRK_LOCKED);
  assign o_sync_err = r_err;
  assign o_fault    = w_nerr;

endmodule

// File: rtl/rom_bus_responder.sv
// ROM-side bus responder: captures the 12-bit address, checks chip select,
// and returns the addressed ROM byte as OPR (M1) then OPA (M2).
module rom_bus_responder
  import rom_bus_responder_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'd0,
  parameter int         ROM_AW  = 8
) (
  input  logic              toggle_clk,
  input  logic              rst_n,
  rom_bus_responder_if.slave bus,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [2:0]        phase,
  output logic              locked,
  output logic              selected,
  output logic              sync_err
);

  phase_e                w_phase;
  logic                  w_locked;
  logic                  w_fault;
  logic [NIBBLE_W-1:0]   r_addr_lo;
  logic [NIBBLE_W-1:0]   r_d_out;
  logic                  r_d_oe;
  logic                  r_sel;
  logic                  w_hit;

  cycle_tracker u_trk (
    .i_clk      (toggle_clk),
    .i_rst_n    (rst_n),
    .i_sync     (bus.sync),
    .o_phase    (w_phase),
    .o_locked   (w_locked),
    .o_sync_err (sync_err),
    .o_fault    (w_fault)
  );

  assign w_hit = (bus.d_in == CHIP_ID);

  // Address capture and data drive; any SYNC (normal or not) or fault ends the drive
  always_ff @(posedge toggle_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_lo <= '0;
      rom_addr  <= '0;
      r_sel     <= 1'b0;
      r_d_out   <= '0;
      r_d_oe    <= 1'b0;
    end else if (w_fault || bus.sync) begin
      r_sel   <= 1'b0;
      r_d_oe  <= 1'b0;
      r_d_out <= '0;
    end else if (w_locked) begin
      case (w_phase)
        A1: r_addr_lo <= bus.d_in;
        A2: rom_addr  <= ROM_AW'({bus.d_in, r_addr_lo});
        A3: begin
          r_sel <= w_hit;
          if (w_hit) begin
            r_d_out <= rom_data[7:4];
            r_d_oe  <= 1'b1;
          end
        end
        // rom_addr is stable, so the low nibble comes from the same byte
        M1: if (r_sel) r_d_out <= rom_data[3:0];
        M2: begin
          r_d_oe  <= 1'b0;
          r_d_out <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.d_out = r_d_out;
  assign bus.d_oe  = r_d_oe;
  assign phase     = w_phase;
  assign locked    = w_locked;
  assign selected  = r_sel;

endmodule

// File: tb/tb_rom_bus_responder.sv
// Directed bench for rom_bus_responder: idle lock-up, fetches, SYNC faults, reset mid-drive.
module tb_rom_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] phase;
  logic       locked, selected, sync_err;
  logic [7:0] rom [256];
  int         n_vec = 0;
  int         n_err = 0;

  rom_bus_responder_if bus ();

  rom_bus_responder #(.CHIP_ID(4'd0), .ROM_AW(8)) dut (
    .toggle_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .phase      (phase),
    .locked     (locked),
    .selected   (selected),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present inputs for one clock, then land 1 time unit past the edge
  task automatic tick(input logic s, input logic [3:0] d);
    bus.sync = s;
    bus.d_in = d;
    @(posedge clk);
    #1;
  endtask

  // One bus cycle starting at phase A1, ending after the closing SYNC
  task automatic fetch_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                             input logic exp_sel, input logic [7:0] exp_byte,
                             input logic [7:0] exp_addr);
    tick(1'b0, a1);
    chk("a1_phase", 8'(phase), 8'd1);
    chk("a1_sync_err", 8'(sync_err), 8'd0);
    tick(1'b0, a2);
    chk("a2_rom_addr", rom_addr, exp_addr);
    chk("a2_d_oe", 8'(bus.d_oe), 8'd0);
    tick(1'b0, a3);
    chk("m1_selected", 8'(selected), 8'(exp_sel));
    chk("m1_d_oe", 8'(bus.d_oe), 8'(exp_sel));
    chk("m1_d_out", 8'(bus.d_out), exp_sel ? 8'(exp_byte[7:4]) : 8'd0);
    tick(1'b0, 4'h0);
    chk("m2_d_oe", 8'(bus.d_oe), 8'(exp_sel));
    chk("m2_d_out", 8'(bus.d_out), exp_sel ? 8'(exp_byte[3:0]) : 8'd0);
    tick(1'b0, 4'h0);
    chk("x1_d_oe", 8'(bus.d_oe), 8'd0);
    chk("x1_d_out", 8'(bus.d_out), 8'd0);
    chk("x1_phase", 8'(phase), 8'd5);
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h0);
    chk("x3_phase", 8'(phase), 8'd7);
    chk("x3_d_oe", 8'(bus.d_oe), 8'd0);
    tick(1'b1, 4'h0);
    chk("end_phase", 8'(phase), 8'd0);
    chk("end_selected", 8'(selected), 8'd0);
    chk("end_locked", 8'(locked), 8'd1);
    chk("end_sync_err", 8'(sync_err), 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hC3;
    rom[8'hA4] = 8'h5C;

    // Reset state
    rst_n = 1'b0;
    bus.sync = 1'b0;
    bus.d_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", 8'(phase), 8'd0);
    chk("rst_locked", 8'(locked), 8'd0);
    chk("rst_selected", 8'(selected), 8'd0);
    chk("rst_d_oe", 8'(bus.d_oe), 8'd0);
    chk("rst_d_out", 8'(bus.d_out), 8'd0);
    chk("rst_rom_addr", rom_addr, 8'd0);
    chk("rst_sync_err", 8'(sync_err), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No SYNC yet: stay unlocked at phase 0
    tick(1'b0, 4'hF);
    tick(1'b0, 4'hF);
    chk("unl_locked", 8'(locked), 8'd0);
    chk("unl_phase", 8'(phase), 8'd0);

    // Idle bus (d_in = F): lock on first SYNC, count 0..7, never drive
    tick(1'b1, 4'hF);
    chk("lock_locked", 8'(locked), 8'd1);
    chk("lock_phase", 8'(phase), 8'd0);
    chk("lock_sync_err", 8'(sync_err), 8'd0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k < 8; k++) begin
        tick(1'b0, 4'hF);
        chk("idle_phase", 8'(phase), 8'(k));
        chk("idle_d_oe", 8'(bus.d_oe), 8'd0);
      end
      tick(1'b1, 4'hF);
      chk("idle_wrap", 8'(phase), 8'd0);
      chk("idle_sync_err", 8'(sync_err), 8'd0);
    end
    chk("idle_rom_addr", rom_addr, 8'hFF);

    // Selected fetch of 0xA4 -> 0x5C, unselected (A3=3), another address
    fetch_cycle(4'h4, 4'hA, 4'h0, 1'b1, 8'h5C, 8'hA4);
    fetch_cycle(4'h4, 4'hA, 4'h3, 1'b0, 8'h5C, 8'hA4);
    fetch_cycle(4'h1, 4'h3, 4'h0, 1'b1, 8'hF2, 8'h31);

    // Extra SYNC during M2 while driving
    tick(1'b0, 4'h4);
    tick(1'b0, 4'hA);
    tick(1'b0, 4'h0);
    chk("xs_m1_d_oe", 8'(bus.d_oe), 8'd1);
    tick(1'b0, 4'h0);
    chk("xs_m2_d_oe", 8'(bus.d_oe), 8'd1);
    tick(1'b1, 4'h0);
    chk("xs_sync_err", 8'(sync_err), 8'd1);
    chk("xs_phase", 8'(phase), 8'd0);
    chk("xs_locked", 8'(locked), 8'd1);
    chk("xs_d_oe", 8'(bus.d_oe), 8'd0);
    chk("xs_selected", 8'(selected), 8'd0);
    fetch_cycle(4'h4, 4'hA, 4'h0, 1'b1, 8'h5C, 8'hA4);

    // Missing SYNC at X3: unlock, hold, relock
    for (int k = 0; k < 7; k++) tick(1'b0, 4'h0);
    chk("ms_x3_phase", 8'(phase), 8'd7);
    tick(1'b0, 4'h0);
    chk("ms_sync_err", 8'(sync_err), 8'd1);
    chk("ms_locked", 8'(locked), 8'd0);
    chk("ms_phase", 8'(phase), 8'd0);
    chk("ms_d_oe", 8'(bus.d_oe), 8'd0);
    tick(1'b0, 4'h0);
    chk("ms_err_pulse", 8'(sync_err), 8'd0);
    chk("ms_hold_phase", 8'(phase), 8'd0);
    chk("ms_hold_locked", 8'(locked), 8'd0);
    tick(1'b1, 4'h0);
    chk("ms_relock", 8'(locked), 8'd1);
    fetch_cycle(4'h1, 4'h3, 4'h0, 1'b1, 8'hF2, 8'h31);

    // Reset while driving in M1: drive drops without a clock edge
    tick(1'b0, 4'h4);
    tick(1'b0, 4'hA);
    tick(1'b0, 4'h0);
    chk("rd_pre_d_oe", 8'(bus.d_oe), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_d_oe", 8'(bus.d_oe), 8'd0);
    chk("rd_d_out", 8'(bus.d_out), 8'd0);
    chk("rd_locked", 8'(locked), 8'd0);
    chk("rd_phase", 8'(phase), 8'd0);
    chk("rd_selected", 8'(selected), 8'd0);
    chk("rd_rom_addr", rom_addr, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 4'h0);
      chk("rd_nodrive_d_oe", 8'(bus.d_oe), 8'd0);
      chk("rd_nodrive_locked", 8'(locked), 8'd0);
    end
    tick(1'b1, 4'h0);
    chk("rd_relock", 8'(locked), 8'd1);
    fetch_cycle(4'h4, 4'hA, 4'h0, 1'b1, 8'h5C, 8'hA4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
